// File: rtl/digit_store_pkg.sv
// Shared definitions for the snake-board digit cell: digit width, shift
// direction encoding and the fixed-priority direction picker.
package digit_store_pkg;

  localparam int DIGIT_W = 3;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  // Fixed priority up > down > left > right; losers in the same cycle are ignored.
  function automatic dir_e pick_dir(input logic up, input logic down,
                                    input logic left, input logic right);
    if (up)         return DIR_UP;
    else if (down)  return DIR_DOWN;
    else if (left)  return DIR_LEFT;
    else if (right) return DIR_RIGHT;
    else            return DIR_NONE;
  endfunction

endpackage

// File: rtl/digit_store_shift_reg.sv
// WIDTH-bit digit register: synchronous clear, parallel load, and
// shift-left with zero fill (MSB leaves first). Exposes msb and a nonzero flag.
module digit_shift_reg
  import digit_store_pkg::*;
#(
  parameter int WIDTH = DIGIT_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_value,
  output logic             msb,
  output logic             nonzero
);

  logic [WIDTH-1:0] digit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (clear)      digit <= '0;
    else if (load)  digit <= load_value;
    else if (shift) digit <= {digit[WIDTH-2:0], 1'b0};
  end

  assign msb     = digit[WIDTH-1];
  assign nonzero = |digit;

endmodule

// File: rtl/digit_store.sv
// One snake-board cell: stores a digit, loads it from user_input and streams
// it MSB-first toward the single highest-priority requesting neighbour.
module digit_store
  import digit_store_pkg::*;
#(
  parameter int WIDTH = DIGIT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             up_shift,
  input  logic             down_shift,
  input  logic             left_shift,
  input  logic             right_shift,
  input  logic [WIDTH-1:0] user_input,
  output logic             out_up,
  output logic             out_down,
  output logic             out_left,
  output logic             out_right,
  output logic             data_out
);

  dir_e dir;
  logic msb;
  logic shift_req;

  assign dir       = pick_dir(up_shift, down_shift, left_shift, right_shift);
  assign shift_req = (dir != DIR_NONE);

  // Reset and load precedence over shifting lives inside the register.
  digit_shift_reg #(.WIDTH(WIDTH)) u_reg (
    .clk       (clk),
    .clear     (reset),
    .load      (set),
    .shift     (shift_req),
    .load_value(user_input),
    .msb       (msb),
    .nonzero   (data_out)
  );

  // NOTE: every output gets a default before the case so no latch is inferred
  // on paths where no direction is selected.
  always_comb begin
    out_up    = 1'b0;
    out_down  = 1'b0;
    out_left  = 1'b0;
    out_right = 1'b0;
    if (!reset && !set) begin
      unique case (dir)
        DIR_UP:    out_up    = msb;
        DIR_DOWN:  out_down  = msb;
        DIR_LEFT:  out_left  = msb;
        DIR_RIGHT: out_right = msb;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_store.sv
// Self-checking bench for digit_store: directed vector table followed by
// randomized cycles checked against an arithmetic reference model.
module tb_digit_store;

  localparam int W = 3;

  logic clk = 1'b0;
  logic reset = 1'b0, set = 1'b0;
  logic up_shift = 1'b0, down_shift = 1'b0, left_shift = 1'b0, right_shift = 1'b0;
  logic [W-1:0] user_input = '0;
  logic out_up, out_down, out_left, out_right, data_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  digit_store #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .set        (set),
    .up_shift   (up_shift),
    .down_shift (down_shift),
    .left_shift (left_shift),
    .right_shift(right_shift),
    .user_input (user_input),
    .out_up     (out_up),
    .out_down   (out_down),
    .out_left   (out_left),
    .out_right  (out_right),
    .data_out   (data_out)
  );

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] shifts;    // {up, down, left, right}
    logic [W-1:0] ui;
    logic [3:0] exp_out;   // {out_up, out_down, out_left, out_right} before the edge
    logic       exp_data;  // data_out after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic ld, input logic [3:0] sh,
                     input logic [W-1:0] ui, input logic [3:0] eo, input logic ed);
    vec_t v;
    v.rst = rst; v.ld = ld; v.shifts = sh; v.ui = ui; v.exp_out = eo; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic ld, input logic [3:0] sh,
                       input logic [W-1:0] ui);
    reset = rst; set = ld;
    up_shift = sh[3]; down_shift = sh[2]; left_shift = sh[1]; right_shift = sh[0];
    user_input = ui;
  endtask

  // Reference model state: the digit as a plain integer.
  int model_digit;

  initial begin
    // Reset then idle
    add(1, 0, 4'b0000, 3'b000, 4'b0000, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 4'b0000, 3'b000, 4'b0000, 0);
    // Load 111, shift up four times
    add(0, 1, 4'b0000, 3'b111, 4'b0000, 1);
    add(0, 0, 4'b1000, 3'b000, 4'b1000, 1);
    add(0, 0, 4'b1000, 3'b000, 4'b1000, 1);
    add(0, 0, 4'b1000, 3'b000, 4'b1000, 0);
    add(0, 0, 4'b1000, 3'b000, 4'b0000, 0);
    // Empty digit shifted down
    for (int i = 0; i < 4; i++) add(0, 0, 4'b0100, 3'b000, 4'b0000, 0);
    // Load 010, shift right four times
    add(0, 1, 4'b0000, 3'b010, 4'b0000, 1);
    add(0, 0, 4'b0001, 3'b000, 4'b0000, 1);
    add(0, 0, 4'b0001, 3'b000, 4'b0001, 0);
    add(0, 0, 4'b0001, 3'b000, 4'b0000, 0);
    add(0, 0, 4'b0001, 3'b000, 4'b0000, 0);
    // Priority: up beats left
    add(0, 1, 4'b0000, 3'b100, 4'b0000, 1);
    add(0, 0, 4'b1010, 3'b000, 4'b1000, 0);
    // Load beats shift; contents 101 verified by shifting out left
    add(0, 1, 4'b0001, 3'b101, 4'b0000, 1);
    add(0, 0, 4'b0000, 3'b000, 4'b0000, 1);
    add(0, 0, 4'b0010, 3'b000, 4'b0010, 1);
    add(0, 0, 4'b0010, 3'b000, 4'b0000, 1);
    add(0, 0, 4'b0010, 3'b000, 4'b0010, 0);
    // Reset mid-sequence
    add(0, 1, 4'b0000, 3'b111, 4'b0000, 1);
    add(0, 0, 4'b1000, 3'b000, 4'b1000, 1);
    add(1, 0, 4'b1000, 3'b000, 4'b0000, 0);
    add(0, 0, 4'b1000, 3'b000, 4'b0000, 0);
    // Direction change mid-word continues from current MSB
    add(0, 1, 4'b0000, 3'b101, 4'b0000, 1);
    add(0, 0, 4'b1000, 3'b000, 4'b1000, 1);
    add(0, 0, 4'b0100, 3'b000, 4'b0000, 1);
    add(0, 0, 4'b0001, 3'b000, 4'b0001, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].shifts, vecs[i].ui);
      @(negedge clk);
      check($sformatf("vec%0d_outs", i), {28'd0, out_up, out_down, out_left, out_right},
            {28'd0, vecs[i].exp_out});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_data", i), {31'd0, data_out}, {31'd0, vecs[i].exp_data});
    end

    // Randomized phase; the table leaves the digit at zero.
    model_digit = 0;
    for (int n = 0; n < 400; n++) begin
      logic r, l;
      logic [3:0] sh;
      logic [W-1:0] ui;
      logic [3:0] exp_o;
      int bit_out;
      r  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 5) == 0);
      sh = 4'($urandom);
      ui = W'($urandom);
      drive(r, l, sh, ui);

      bit_out = (model_digit >> (W - 1)) % 2;
      exp_o = 4'b0000;
      if (!r && !l) begin
        if (sh[3])      exp_o = 4'(bit_out << 3);
        else if (sh[2]) exp_o = 4'(bit_out << 2);
        else if (sh[1]) exp_o = 4'(bit_out << 1);
        else if (sh[0]) exp_o = 4'(bit_out);
      end
      if (r)               model_digit = 0;
      else if (l)          model_digit = int'(ui);
      else if (sh != 4'b0) model_digit = (model_digit * 2) % (1 << W);

      @(negedge clk);
      check($sformatf("rnd%0d_outs", n), {28'd0, out_up, out_down, out_left, out_right},
            {28'd0, exp_o});
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_data", n), {31'd0, data_out}, {31'd0, model_digit != 0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
